g_curve_lut: RTL and testbench

Parametrised, runtime-reloadable camera-response (g-curve) lookup for the HDR pipeline. One 2^PIXEL_W-entry table per colour channel, all channels looked up in parallel every enabled cycle. Tables are double-banked: a host loads a shadow bank while lookups continue from the active bank, then swaps the banks atomically on commit. After reset the block fills all tables with an identity curve, so the pipeline is usable before any load.

---
 rtl/g_curve_lut.sv | 136 +++++++++++++
 tb/tb_g_curve_lut.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/g_curve_lut.sv
// g_curve_lut: double-banked per-channel g-curve lookup.
// Identity fill after reset, shadow-bank load, atomic commit.
module g_curve_lut #(
  parameter int PIXEL_W  = 5,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int CH_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         in_valid,
  input  logic [CHANNELS*PIXEL_W-1:0]  pixel,
  output logic                         out_valid,
  output logic [CHANNELS*DATA_W-1:0]   data,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CH_W-1:0]              cfg_chan,
  input  logic [PIXEL_W-1:0]           cfg_addr,
  input  logic [DATA_W-1:0]            cfg_data,
  input  logic                         cfg_commit,
  output logic                         active_bank,
  output logic                         init_done,
  output logic                         cfg_err
);

  localparam int DEPTH = 1 << PIXEL_W;
  localparam int SH    = DATA_W - PIXEL_W;
  localparam logic [CH_W:0] NCH = (CH_W+1)'(CHANNELS);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                       state_q;
  logic [PIXEL_W-1:0]           cnt_q;
  logic [PIXEL_W-1:0]           cnt_d;
  logic                         out_valid_q;
  logic [CHANNELS*DATA_W-1:0]   data_q;
  logic [CHANNELS*DATA_W-1:0]   look_d;
  logic                         cfg_ready_q;
  logic                         bank_q;
  logic                         init_done_q;
  logic                         cfg_err_q;
  logic [DATA_W-1:0]            init_val;
  logic                         cfg_fire;
  logic                         commit_fire;
  logic                         chan_bad;
  logic                         wr_bank;

  logic [DATA_W-1:0] mem_q [2][CHANNELS][DEPTH];

  assign cnt_d       = cnt_q + 1'b1;
  assign init_val    = DATA_W'(cnt_q) << SH;
  assign cfg_fire    = cfg_valid & cfg_ready_q;
  assign commit_fire = cfg_commit & cfg_ready_q;
  assign chan_bad    = {1'b0, cfg_chan} >= NCH;
  assign wr_bank     = ~bank_q;

  assign out_valid   = out_valid_q;
  assign data        = data_q;
  assign cfg_ready   = cfg_ready_q;
  assign active_bank = bank_q;
  assign init_done   = init_done_q;
  assign cfg_err     = cfg_err_q;

  // Parallel read of every channel from the active bank.
  always_comb begin
    look_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      look_d[c*DATA_W +: DATA_W] =
        mem_q[bank_q][c][pixel[c*PIXEL_W +: PIXEL_W]];
    end
  end

  // Table storage: identity fill in INIT, shadow-bank writes in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        for (int b = 0; b < 2; b++) begin
          for (int c = 0; c < CHANNELS; c++) begin
            mem_q[b][c][cnt_q] <= init_val;
          end
        end
      end else if (cfg_fire) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (cfg_chan == CH_W'(c)) begin
            mem_q[wr_bank][c][cfg_addr] <= cfg_data;
          end
        end
      end
    end
  end

  // Control FSM with registered lookup and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      init_done_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      bank_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == '1) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
            cfg_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (clk_en) begin
            out_valid_q <= in_valid;
            data_q      <= look_d;
          end
          if (cfg_fire && chan_bad) begin
            cfg_err_q <= 1'b1;
          end
          if (commit_fire) begin
            bank_q <= ~bank_q;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g_curve_lut.sv
// tb_g_curve_lut: scoreboard bench for g_curve_lut.
// Reference tables model both banks and the commit ordering.
module tb_g_curve_lut;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        in_valid;
  logic [14:0] pixel;
  logic        out_valid;
  logic [23:0] data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_chan;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_commit;
  logic        active_bank;
  logic        init_done;
  logic        cfg_err;

  g_curve_lut dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_valid(in_valid), .pixel(pixel),
    .out_valid(out_valid), .data(data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .active_bank(active_bank), .init_done(init_done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  mdl [2][3][32];
  logic        mbank;
  logic        merr;
  logic        lv;
  logic [23:0] ld;
  logic [24:0] exp_q [$];
  logic [7:0]  curve [32];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pix3(input logic [4:0] a,
                                       input logic [4:0] b,
                                       input logic [4:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [23:0] mlook(input logic [14:0] p);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      r[c*8 +: 8] = mdl[mbank][c][p[c*5 +: 5]];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 32; i++)
          mdl[b][c][i] = 8'(i << 3);
    mbank = 1'b0;
    merr  = 1'b0;
    lv    = 1'b0;
    ld    = '0;
  endtask

  // One RUN cycle: drive, predict, edge, compare.
  task automatic step(input logic en, input logic iv,
                      input logic [14:0] p, input logic cv,
                      input logic [1:0] ch, input logic [4:0] a,
                      input logic [7:0] d, input logic cm);
    logic [24:0] e;
    clk_en     = en;
    in_valid   = iv;
    pixel      = p;
    cfg_valid  = cv;
    cfg_chan   = ch;
    cfg_addr   = a;
    cfg_data   = d;
    cfg_commit = cm;
    if (en) begin
      lv = iv;
      ld = mlook(p);
    end
    exp_q.push_back({lv, ld});
    if (cv) begin
      if (ch < 2'd3) mdl[~mbank][ch][a] = d;
      else merr = 1'b1;
    end
    if (cm) mbank = ~mbank;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    e = exp_q.pop_front();
    chk("out_valid", 32'(out_valid), 32'(e[24]));
    chk("data", 32'(data), 32'(e[23:0]));
    chk("active_bank", 32'(active_bank), 32'(mbank));
    chk("cfg_err", 32'(cfg_err), 32'(merr));
  endtask

  task automatic look(input logic [14:0] p);
    step(1'b1, 1'b1, p, 1'b0, 2'd0, 5'd0, 8'd0, 1'b0);
  endtask

  // Reset for two edges, then walk the identity fill.
  task automatic do_reset();
    rst_n      = 1'b0;
    clk_en     = 1'b1;
    in_valid   = 1'b1;
    pixel      = pix3(5'h1F, 5'h1F, 5'h1F);
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    cfg_chan   = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst data", 32'(data), 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);
    chk("rst cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst cfg_err", 32'(cfg_err), 32'd0);
    chk("rst active_bank", 32'(active_bank), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      chk("init out_valid", 32'(out_valid), 32'd0);
      chk("init data", 32'(data), 32'd0);
      chk("init_done", 32'(init_done), 32'(i == 32));
      chk("init cfg_ready", 32'(cfg_ready), 32'(i == 32));
    end
    model_reset();
  endtask

  initial begin
    curve = '{8'd1, 8'd0, 8'd1, 8'd3, 8'd6, 8'd9, 8'd11, 8'd13,
              8'd13, 8'd12, 8'd11, 8'd11, 8'd11, 8'd12, 8'd12, 8'd13,
              8'd13, 8'd13, 8'd13, 8'd13, 8'd13, 8'd13, 8'd15, 8'd17,
              8'd19, 8'd21, 8'd22, 8'd24, 8'd24, 8'd25, 8'd26, 8'd27};

    do_reset();
    look(pix3(5'h1F, 5'h1F, 5'h1F));
    chk("first lookup", 32'(data), 32'hF8F8F8);

    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b1, pix3(5'h04, 5'h04, 5'h04),
           1'b1, 2'd2, 5'(i), curve[i], 1'b0);
    look(pix3(5'h04, 5'h04, 5'h04));
    chk("pre-commit ch2", 32'(data[23:16]), 32'h20);

    step(1'b1, 1'b1, pix3(5'h04, 5'h04, 5'h04),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b1);
    chk("commit-cycle ch2", 32'(data[23:16]), 32'h20);
    look(pix3(5'h04, 5'h04, 5'h04));
    chk("post-commit ch2", 32'(data[23:16]), 32'h06);
    look(pix3(5'h1F, 5'h1F, 5'h1F));
    chk("ch2 1F", 32'(data[23:16]), 32'h1B);
    chk("ch0/1 identity", 32'(data[15:0]), 32'hF8F8);

    step(1'b1, 1'b0, pix3(5'h01, 5'h02, 5'h03),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b0);
    step(1'b0, 1'b1, pix3(5'h05, 5'h06, 5'h07),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b0);
    step(1'b0, 1'b0, pix3(5'h08, 5'h09, 5'h0A),
         1'b1, 2'd2, 5'd5, 8'h55, 1'b0);
    step(1'b0, 1'b1, pix3(5'h0B, 5'h0C, 5'h0D),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b0);
    step(1'b0, 1'b1, pix3(5'h0E, 5'h0F, 5'h10),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b1);
    step(1'b0, 1'b0, pix3(5'h11, 5'h12, 5'h13),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b0);
    look(pix3(5'h05, 5'h05, 5'h05));
    chk("stall write ch2", 32'(data[23:16]), 32'h55);

    step(1'b1, 1'b1, pix3(5'h07, 5'h07, 5'h07),
         1'b1, 2'd1, 5'd7, 8'hAA, 1'b1);
    look(pix3(5'h07, 5'h07, 5'h07));
    chk("wr+commit ch1", 32'(data[15:8]), 32'hAA);

    step(1'b1, 1'b1, pix3(5'h09, 5'h09, 5'h09),
         1'b1, 2'd3, 5'd9, 8'h77, 1'b0);
    step(1'b1, 1'b1, pix3(5'h09, 5'h09, 5'h09),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b1);
    for (int i = 0; i < 12; i++)
      look(15'($urandom));

    do_reset();
    chk("re-init bank", 32'(active_bank), 32'd0);
    for (int i = 0; i < 10; i++)
      look(15'($urandom));
    step(1'b1, 1'b1, pix3(5'h07, 5'h05, 5'h04),
         1'b0, 2'd0, 5'd0, 8'd0, 1'b1);
    look(pix3(5'h07, 5'h05, 5'h04));
    chk("bank1 identity", 32'(data), 32'h202838);
    for (int i = 0; i < 10; i++)
      look(15'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
